// File: rtl/dpc_counter_pkg.sv
// Shared types and constants for the DPC BCD counters.
package dpc_counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      OP_INC   = 2'b00,
      OP_DEC   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Step timer width; covers STEP_CYCLES up to 15.
   localparam int unsigned TIMER_W = 4;

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the step counter: next-digit and ripple logic.
// Purely combinational; the digit register lives in the parent.
// Ports:
//   digit      in   current BCD digit
//   up         in   increment step selected
//   down       in   decrement step selected
//   carry_in   in   carry (up) or borrow (down) from the lower decade
//   next_digit out  digit value after the step
//   carry_out  out  carry/borrow into the next decade
module bcd_decade
   import dpc_counter_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic       up,
   input  logic       down,
   input  logic       carry_in,
   output bcd_digit_t next_digit,
   output logic       carry_out
);

   // A decade only moves when the lower decades wrapped (or it is digit 0).
   always_comb begin
      next_digit = digit;
      carry_out  = 1'b0;
      if (carry_in) begin
         if (up) begin
            if (digit >= BCD_MAX) begin
               next_digit = 4'd0;
               carry_out  = 1'b1;
            end else begin
               next_digit = digit + 4'd1;
            end
         end else if (down) begin
            if (digit == 4'd0) begin
               next_digit = BCD_MAX;
               carry_out  = 1'b1;
            end else begin
               next_digit = digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_step_counter.sv
// Multi-decade BCD up/down counter with load/clear, carry/borrow/zero flags
// and a Request/Ready/Done handshake modelling a multi-cycle step time.
// Ports:
//   Clk, Rst_n  clock, asynchronous active-low reset
//   Request     operation request, accepted when Request & Ready
//   Op          00 INC, 01 DEC, 10 LOAD, 11 CLEAR
//   LoadData    BCD value for LOAD, sampled at acceptance
//   Ready       idle, can accept a request
//   Done        1-cycle pulse after the edge that updated Out
//   Out         current BCD count, digit 0 in bits [3:0]
//   Carry       pulse with Done when INC wrapped all-9 -> all-0
//   Borrow      pulse with Done when DEC wrapped all-0 -> all-9
//   Zero        Out == 0
//   BadLoad     sticky, a LOAD carried a nibble > 9; cleared by CLEAR
module bcd_step_counter
   import dpc_counter_pkg::*;
#(
   parameter int unsigned DIGITS      = 6,
   parameter int unsigned STEP_CYCLES = 1
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Request,
   input  logic [1:0]            Op,
   input  logic [4*DIGITS-1:0]   LoadData,
   output logic                  Ready,
   output logic                  Done,
   output logic [4*DIGITS-1:0]   Out,
   output logic                  Carry,
   output logic                  Borrow,
   output logic                  Zero,
   output logic                  BadLoad
);

   localparam int unsigned W = 4 * DIGITS;

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   op_t                 op_q, op_d;
   logic [W-1:0]        load_q, load_d;
   logic [W-1:0]        out_d;
   logic                done_d, carry_d, borrow_d, zero_d, bad_d, ready_d;

   op_t                 exec_op;
   logic [W-1:0]        exec_data;
   logic                step_up, step_down;
   logic [W-1:0]        step_out;
   logic                step_wrap;
   logic [W-1:0]        load_clamped;
   logic                load_bad;

   // In IDLE a single-cycle op executes straight from the inputs; a
   // multi-cycle op executes at the end of BUSY from the latched copy.
   assign exec_op   = (state_q == ST_IDLE) ? op_t'(Op) : op_q;
   assign exec_data = (state_q == ST_IDLE) ? LoadData : load_q;
   assign step_up   = (exec_op == OP_INC);
   assign step_down = (exec_op == OP_DEC);

   // Decade ripple chain; each stage has its own carry net.
   for (genvar i = 0; i < DIGITS; i++) begin : g_dec
      logic cin;
      logic cout;
      if (i == 0) begin : g_first
         assign cin = 1'b1;
      end else begin : g_rest
         assign cin = g_dec[i-1].cout;
      end
      bcd_decade u_decade (
         .digit      (Out[4*i +: 4]),
         .up         (step_up),
         .down       (step_down),
         .carry_in   (cin),
         .next_digit (step_out[4*i +: 4]),
         .carry_out  (cout)
      );
   end

   assign step_wrap = g_dec[DIGITS-1].cout;

   // Clamp non-BCD load nibbles to 9 and flag them.
   always_comb begin
      load_clamped = exec_data;
      load_bad     = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (exec_data[4*i +: 4] > BCD_MAX) begin
            load_clamped[4*i +: 4] = BCD_MAX;
            load_bad               = 1'b1;
         end
      end
   end

   // Next-state, step timer, op latch and result selection.
   always_comb begin
      logic apply;
      state_d  = state_q;
      timer_d  = timer_q;
      op_d     = op_q;
      load_d   = load_q;
      out_d    = Out;
      bad_d    = BadLoad;
      done_d   = 1'b0;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      apply    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Request) begin
               op_d   = op_t'(Op);
               load_d = LoadData;
               if (STEP_CYCLES <= 1) begin
                  apply = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  timer_d = TIMER_W'(STEP_CYCLES - 2);
               end
            end
         end
         ST_BUSY: begin
            if (timer_q == '0) begin
               apply   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (apply) begin
         done_d = 1'b1;
         case (exec_op)
            OP_INC: begin
               out_d   = step_out;
               carry_d = step_wrap;
            end
            OP_DEC: begin
               out_d    = step_out;
               borrow_d = step_wrap;
            end
            OP_LOAD: begin
               out_d = load_clamped;
               if (load_bad) bad_d = 1'b1;
            end
            OP_CLEAR: begin
               out_d = '0;
               bad_d = 1'b0;
            end
            default: out_d = Out;
         endcase
      end

      zero_d  = (out_d == '0);
      ready_d = (state_d == ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         op_q    <= OP_INC;
         load_q  <= '0;
         Out     <= '0;
         Ready   <= 1'b1;
         Done    <= 1'b0;
         Carry   <= 1'b0;
         Borrow  <= 1'b0;
         Zero    <= 1'b1;
         BadLoad <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         op_q    <= op_d;
         load_q  <= load_d;
         Out     <= out_d;
         Ready   <= ready_d;
         Done    <= done_d;
         Carry   <= carry_d;
         Borrow  <= borrow_d;
         Zero    <= zero_d;
         BadLoad <= bad_d;
      end
   end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter: three instances cover
// 6 digits / 1 cycle, 3 digits / 1 cycle and 6 digits / 4 cycles.
module tb_bcd_step_counter;

   localparam logic [1:0] C_INC = 2'b00;
   localparam logic [1:0] C_DEC = 2'b01;
   localparam logic [1:0] C_LD  = 2'b10;
   localparam logic [1:0] C_CLR = 2'b11;

   logic clk;
   logic rst_n, rst_c_n;
   int   total, bad;
   int   cnt, idx;

   logic        a_req, a_ready, a_done, a_carry, a_borrow, a_zero, a_bad;
   logic [1:0]  a_op;
   logic [23:0] a_ld, a_out;

   logic        b_req, b_ready, b_done, b_carry, b_borrow, b_zero, b_bad;
   logic [1:0]  b_op;
   logic [11:0] b_ld, b_out;

   logic        c_req, c_ready, c_done, c_carry, c_borrow, c_zero, c_bad;
   logic [1:0]  c_op;
   logic [23:0] c_ld, c_out;

   bcd_step_counter #(.DIGITS(6), .STEP_CYCLES(1)) u_a (
      .Clk(clk), .Rst_n(rst_n), .Request(a_req), .Op(a_op), .LoadData(a_ld),
      .Ready(a_ready), .Done(a_done), .Out(a_out), .Carry(a_carry),
      .Borrow(a_borrow), .Zero(a_zero), .BadLoad(a_bad));

   bcd_step_counter #(.DIGITS(3), .STEP_CYCLES(1)) u_b (
      .Clk(clk), .Rst_n(rst_n), .Request(b_req), .Op(b_op), .LoadData(b_ld),
      .Ready(b_ready), .Done(b_done), .Out(b_out), .Carry(b_carry),
      .Borrow(b_borrow), .Zero(b_zero), .BadLoad(b_bad));

   bcd_step_counter #(.DIGITS(6), .STEP_CYCLES(4)) u_c (
      .Clk(clk), .Rst_n(rst_c_n), .Request(c_req), .Op(c_op), .LoadData(c_ld),
      .Ready(c_ready), .Done(c_done), .Out(c_out), .Carry(c_carry),
      .Borrow(c_borrow), .Zero(c_zero), .BadLoad(c_bad));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic a_do(input logic [1:0] op, input logic [23:0] d);
      a_op = op; a_ld = d; a_req = 1'b1;
      @(posedge clk); #1;
      a_req = 1'b0;
   endtask

   task automatic b_do(input logic [1:0] op, input logic [11:0] d);
      b_op = op; b_ld = d; b_req = 1'b1;
      @(posedge clk); #1;
      b_req = 1'b0;
   endtask

   // Issue on instance C and wait until after its update edge (k+3).
   task automatic c_do(input logic [1:0] op, input logic [23:0] d);
      c_op = op; c_ld = d; c_req = 1'b1;
      @(posedge clk); #1;
      c_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; cnt = 0; idx = 0;
      rst_n = 1'b1; rst_c_n = 1'b1;
      a_req = 1'b0; a_op = C_INC; a_ld = '0;
      b_req = 1'b0; b_op = C_INC; b_ld = '0;
      c_req = 1'b0; c_op = C_INC; c_ld = '0;
      #1;
      rst_n = 1'b0; rst_c_n = 1'b0;
      #1;
      chk("rst_out",    32'(a_out),   32'h0);
      chk("rst_ready",  32'(a_ready), 32'h1);
      chk("rst_zero",   32'(a_zero),  32'h1);
      chk("rst_done",   32'(a_done),  32'h0);
      chk("rst_carry",  32'(a_carry), 32'h0);
      chk("rst_borrow", 32'(a_borrow),32'h0);
      chk("rst_badld",  32'(a_bad),   32'h0);
      chk("rst_c_ready",32'(c_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1; rst_c_n = 1'b1;

      // 10 back-to-back INC
      cnt = 0; a_op = C_INC; a_req = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (a_carry) cnt++;
      end
      a_req = 1'b0;
      chk("inc10_out",   32'(a_out),  32'h000010);
      chk("inc10_carry", 32'(cnt),    32'd0);
      chk("inc10_done",  32'(a_done), 32'h1);
      chk("inc10_zero",  32'(a_zero), 32'h0);
      @(posedge clk); #1;
      chk("idle_done",   32'(a_done), 32'h0);
      chk("idle_hold",   32'(a_out),  32'h000010);

      // 20 back-to-back DEC, one borrow on the 11th
      cnt = 0; idx = 0; a_op = C_DEC; a_req = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (a_borrow) begin cnt++; idx = i; end
         if (i == 10) chk("dec10_zero", 32'(a_zero), 32'h1);
         if (i == 11) chk("dec11_out", 32'(a_out), 32'h999999);
      end
      a_req = 1'b0;
      chk("dec20_out",     32'(a_out), 32'h999990);
      chk("dec20_borrows", 32'(cnt),   32'd1);
      chk("dec20_bidx",    32'(idx),   32'd11);

      // LOAD then 100 INC, then CLEAR
      a_do(C_LD, 24'h000155);
      chk("ld155_out",  32'(a_out),   32'h000155);
      chk("ld155_carry",32'(a_carry), 32'h0);
      a_op = C_INC; a_req = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      a_req = 1'b0;
      chk("inc100_out", 32'(a_out),  32'h000255);
      a_do(C_CLR, 24'h0);
      chk("clr_out",    32'(a_out),  32'h0);
      chk("clr_zero",   32'(a_zero), 32'h1);

      // Bad load clamp and sticky flag on the single-cycle instance
      a_do(C_LD, 24'h00A123);
      chk("a_badld_out",  32'(a_out), 32'h009123);
      chk("a_badld_flag", 32'(a_bad), 32'h1);
      a_do(C_LD, 24'h000001);
      chk("a_goodld_sticky", 32'(a_bad), 32'h1);
      a_do(C_CLR, 24'h0);
      chk("a_clr_badld", 32'(a_bad), 32'h0);

      // 3-digit wrap
      b_do(C_LD, 12'h999);
      chk("b_ld_out",   32'(b_out),   32'h999);
      b_do(C_INC, 12'h0);
      chk("b_wrap_out", 32'(b_out),   32'h000);
      chk("b_wrap_cy",  32'(b_carry), 32'h1);
      chk("b_wrap_zero",32'(b_zero),  32'h1);
      @(posedge clk); #1;
      chk("b_cy_pulse", 32'(b_carry), 32'h0);
      b_do(C_DEC, 12'h0);
      chk("b_dec_out",  32'(b_out),    32'h999);
      chk("b_dec_bw",   32'(b_borrow), 32'h1);
      chk("b_dec_cy",   32'(b_carry),  32'h0);

      // 4-cycle step with a dropped request while busy
      c_op = C_INC; c_req = 1'b1;
      @(posedge clk); #1;
      chk("c_k_ready", 32'(c_ready), 32'h0);
      chk("c_k_out",   32'(c_out),   32'h0);
      c_op = C_LD; c_ld = 24'h555555;
      @(posedge clk); #1;
      chk("c_k1_ready", 32'(c_ready), 32'h0);
      chk("c_k1_done",  32'(c_done),  32'h0);
      @(posedge clk); #1;
      chk("c_k2_ready", 32'(c_ready), 32'h0);
      chk("c_k2_out",   32'(c_out),   32'h0);
      @(posedge clk); #1;
      c_req = 1'b0;
      chk("c_k3_out",   32'(c_out),   32'h000001);
      chk("c_k3_ready", 32'(c_ready), 32'h1);
      chk("c_k3_done",  32'(c_done),  32'h1);
      @(posedge clk); #1;
      chk("c_k4_done",  32'(c_done),  32'h0);
      chk("c_k4_drop",  32'(c_out),   32'h000001);

      // Reset mid-BUSY aborts the op
      c_op = C_INC; c_req = 1'b1;
      @(posedge clk); #1;
      c_req = 1'b0;
      chk("c_busy_ready", 32'(c_ready), 32'h0);
      @(posedge clk); #1;
      rst_c_n = 1'b0;
      #1;
      chk("c_rst_out",   32'(c_out),   32'h0);
      chk("c_rst_ready", 32'(c_ready), 32'h1);
      chk("c_rst_done",  32'(c_done),  32'h0);
      @(negedge clk);
      rst_c_n = 1'b1;
      cnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (c_done) cnt++;
      end
      chk("c_abort_done", 32'(cnt),   32'd0);
      chk("c_abort_out",  32'(c_out), 32'h0);

      // Bad load on the multi-cycle instance
      c_do(C_LD, 24'h00A123);
      chk("c_badld_out",  32'(c_out), 32'h009123);
      chk("c_badld_flag", 32'(c_bad), 32'h1);
      c_do(C_INC, 24'h0);
      chk("c_inc_out",    32'(c_out), 32'h009124);
      chk("c_inc_sticky", 32'(c_bad), 32'h1);
      c_do(C_CLR, 24'h0);
      chk("c_clr_out",    32'(c_out), 32'h0);
      chk("c_clr_badld",  32'(c_bad), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
